muldiv_hilo: RTL and testbench

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo_if.sv | 23 ++
 rtl/muldiv_hilo.sv | 125 ++++++++++++
 tb/tb_muldiv_hilo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between execute and the HI/LO multiply-divide unit.
// The master issues ops and reads HI/LO; the slave is the unit itself.
interface muldiv_hilo_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO unit: single-cycle multiply, 32-step restoring divide, MTHI/MTLO.
// Divide works on magnitudes; signs are reapplied in the FIX cycle.
module muldiv_hilo (
  input logic          clk,
  input logic          reset,
  muldiv_hilo_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DIV  = 2'b10;
  localparam logic [1:0] FIX  = 2'b11;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state;
  logic [31:0] hi_q, lo_q;
  logic [31:0] ma, mb;
  logic        msgn;
  logic [31:0] rem, quo, dvs;
  logic        qneg, rneg, dz;
  logic [5:0]  cnt;

  logic [63:0] ea, eb, prod;
  logic [32:0] trial, diff;
  logic        sgn;
  logic [31:0] amag, bmag;

  always_comb begin
    ea    = {{32{msgn & ma[31]}}, ma};
    eb    = {{32{msgn & mb[31]}}, mb};
    prod  = ea * eb;
    trial = {rem, quo[31]};
    diff  = trial - {1'b0, dvs};
    sgn   = ~bus.op[0];
    amag  = (sgn & bus.a[31]) ? -bus.a : bus.a;
    bmag  = (sgn & bus.b[31]) ? -bus.b : bus.b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi_q  <= '0;
      lo_q  <= '0;
      ma    <= '0;
      mb    <= '0;
      msgn  <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULT, OP_MULTU: begin
                ma    <= bus.a;
                mb    <= bus.b;
                msgn  <= sgn;
                state <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.b == '0) begin
                  dz    <= 1'b1;
                  state <= FIX;
                end else begin
                  dz    <= 1'b0;
                  quo   <= amag;
                  dvs   <= bmag;
                  rem   <= '0;
                  qneg  <= sgn & (bus.a[31] ^ bus.b[31]);
                  rneg  <= sgn & bus.a[31];
                  cnt   <= '0;
                  state <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          {hi_q, lo_q} <= prod;
          state        <= IDLE;
        end
        DIV: begin
          // quo doubles as the dividend shifter and the quotient collector
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (!dz) begin
            lo_q <= qneg ? -quo : quo;
            hi_q <= rneg ? -rem : rem;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = !reset && !bus.flush && ((state == MUL) || (state == FIX));
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: stimulus queues expected HI/LO and
// busy latency; a monitor pops one entry per done pulse and compares.
module tb_muldiv_hilo;
  logic clk;
  logic reset;

  muldiv_hilo_if bus ();

  muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t cur;
    bit   pend;
    int   bcnt;
    pend = 0;
    bcnt = 0;
    cur  = '{hi: 32'h0, lo: 32'h0, lat: 0};
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("sb_hi", bus.hi, cur.hi);
        chk("sb_lo", bus.lo, cur.lo);
        pend = 0;
      end
      if (!bus.busy) bcnt = 0;
      else bcnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          cur = exp_q.pop_front();
          chk("sb_latency", bcnt, cur.lat);
          pend = 1;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) chk("busy_timeout", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi,
                     input logic [31:0] elo, input int lat);
    exp_q.push_back('{hi: ehi, lo: elo, lat: lat});
    issue(o, x, y);
    wait_idle();
  endtask

  initial begin
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.a        = '0;
    bus.b        = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run(3'b001, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1);
    run(3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1);
    run(3'b001, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1);
    run(3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    run(3'b010, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33);
    run(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    issue(3'b100, 32'h11, 32'h0);
    chk("mthi_busy", 32'(bus.busy), 32'h0);
    chk("mthi_hi", bus.hi, 32'h11);
    issue(3'b101, 32'h22, 32'h0);
    chk("mtlo_done", 32'(bus.done), 32'h0);
    chk("mtlo_lo", bus.lo, 32'h22);

    run(3'b011, 32'h7, 32'h0, 32'h11, 32'h22, 1);

    issue(3'b011, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    chk("flush_done_cycle", 32'(bus.done), 32'h0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'h0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);

    bus.flush = 1'b1;
    issue(3'b100, 32'hDEAD, 32'h0);
    bus.flush = 1'b0;
    chk("idle_flush_hi", bus.hi, 32'h11);

    issue(3'b110, 32'h5, 32'h5);
    chk("reserved_busy", 32'(bus.busy), 32'h0);
    chk("reserved_hi", bus.hi, 32'h11);

    exp_q.push_back('{hi: 32'd2, lo: 32'd14, lat: 33});
    issue(3'b011, 32'd100, 32'd7);
    bus.op_valid = 1'b1;
    bus.op       = 3'b100;
    bus.a        = 32'h1234;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    wait_idle();
    chk("busy_mthi_ignored", bus.hi, 32'd2);

    issue(3'b100, 32'h1234, 32'h0);
    chk("idle_mthi_hi", bus.hi, 32'h1234);
    chk("idle_mthi_busy", 32'(bus.busy), 32'h0);

    issue(3'b010, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_hi", bus.hi, 32'h0);
    chk("mid_rst_lo", bus.lo, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_stays_zero", bus.lo, 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
